// File: rtl/ofe_pkg.sv
// Shared definitions for the output flip-flop pipe bank: depth limit,
// ceiling-log2 helper and the fill-counter type.
package ofe_pkg;

  localparam int OFE_MAX_STAGES = 4;

  function automatic int ofe_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int OFE_FILL_W = ofe_clog2(OFE_MAX_STAGES + 1);

  // Wide enough for any legal depth; the top narrows it to its own STAGES.
  typedef logic [OFE_FILL_W-1:0] ofe_fill_t;

endpackage

// File: rtl/ofe_stage.sv
// One WIDTH+1-bit register slice of the output pipe: data plus tristate
// control, with synchronous active-low reset, synchronous preset and enable.
module ofe_stage #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter logic [WIDTH-1:0] PD_VAL   = '1,
  parameter logic             TS_INIT  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pd,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_td,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tq
);

  logic [WIDTH-1:0] r_q;
  logic             r_tq;

  // Reset outranks preset, preset outranks enable; control is ignored in reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q  <= INIT_VAL;
      r_tq <= TS_INIT;
    end else if (i_pd) begin
      r_q  <= PD_VAL;
      r_tq <= TS_INIT;
    end else if (i_en) begin
      r_q  <= i_d;
      r_tq <= i_td;
    end
  end

  assign o_q  = r_q;
  assign o_tq = r_tq;

endmodule

// File: rtl/ofe_pipe_bank.sv
// Parametrised output FF bank: STAGES-deep data/tristate pipe in front of the
// pad buffers, with a priming counter that raises QVALID once real data arrives.
module ofe_pipe_bank
  import ofe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               STAGES   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter logic [WIDTH-1:0] PD_VAL   = '1,
  parameter logic             TS_INIT  = 1'b1
) (
  input  logic             ECLK,
  input  logic             GSRN,
  input  logic [WIDTH-1:0] D,
  input  logic             TD,
  input  logic             SP,
  input  logic             PD,
  output logic [WIDTH-1:0] Q,
  output logic             TQ,
  output logic             QVALID
);

  localparam int CNT_W = ofe_clog2(STAGES + 1);

  logic [STAGES:0][WIDTH-1:0] w_d_chain;
  logic [STAGES:0]            w_t_chain;

  logic [CNT_W-1:0] r_fill_cnt;
  logic             r_qvalid;
  ofe_fill_t        w_fill_cur;
  ofe_fill_t        w_fill_nxt;

  assign w_d_chain[0] = D;
  assign w_t_chain[0] = TD;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      ofe_stage #(
        .WIDTH   (WIDTH),
        .INIT_VAL(INIT_VAL),
        .PD_VAL  (PD_VAL),
        .TS_INIT (TS_INIT)
      ) u_stage (
        .i_clk  (ECLK),
        .i_rst_n(GSRN),
        .i_pd   (PD),
        .i_en   (SP),
        .i_d    (w_d_chain[g]),
        .i_td   (w_t_chain[g]),
        .o_q    (w_d_chain[g+1]),
        .o_tq   (w_t_chain[g+1])
      );
    end
  endgenerate

  // Saturating increment: the count parks at STAGES and never wraps.
  assign w_fill_cur = ofe_fill_t'(r_fill_cnt);

  always_comb begin
    w_fill_nxt = w_fill_cur;
    if (w_fill_cur != ofe_fill_t'(STAGES)) w_fill_nxt = w_fill_cur + ofe_fill_t'(1);
  end

  // QVALID is registered off the next count so it rises on the final priming edge.
  always_ff @(posedge ECLK) begin
    if (!GSRN) begin
      r_fill_cnt <= '0;
      r_qvalid   <= 1'b0;
    end else if (PD) begin
      r_fill_cnt <= '0;
      r_qvalid   <= 1'b0;
    end else if (SP) begin
      r_fill_cnt <= CNT_W'(w_fill_nxt);
      r_qvalid   <= (w_fill_nxt == ofe_fill_t'(STAGES));
    end
  end

  assign Q      = w_d_chain[STAGES];
  assign TQ     = w_t_chain[STAGES];
  assign QVALID = r_qvalid;

endmodule

// File: tb/tb_ofe_pipe_bank.sv
// Bench for ofe_pipe_bank: three instances (8x2, 1x1, 64x4) share one control
// stream; a per-instance expected queue models the pipe latency and priming.
module tb_ofe_pipe_bank;

  logic        ECLK;
  logic        GSRN;
  logic        PD;
  logic        SP;
  logic        TD;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [63:0] d64;

  logic [7:0]  q2;
  logic        tq2;
  logic        qv2;
  logic [0:0]  q1;
  logic        tq1;
  logic        qv1;
  logic [63:0] q4;
  logic        tq4;
  logic        qv4;

  int errors;
  int checks;

  logic [8:0]  exp_q2[$];
  logic [1:0]  exp_q1[$];
  logic [64:0] exp_q4[$];
  logic [8:0]  exp2;
  logic [1:0]  exp1;
  logic [64:0] exp4;
  logic        expv2;
  logic        expv1;
  logic        expv4;

  ofe_pipe_bank #(.WIDTH(8), .STAGES(2)) u_d2 (
    .ECLK(ECLK), .GSRN(GSRN), .D(d8), .TD(TD), .SP(SP), .PD(PD),
    .Q(q2), .TQ(tq2), .QVALID(qv2)
  );

  ofe_pipe_bank #(.WIDTH(1), .STAGES(1)) u_d1 (
    .ECLK(ECLK), .GSRN(GSRN), .D(d1), .TD(TD), .SP(SP), .PD(PD),
    .Q(q1), .TQ(tq1), .QVALID(qv1)
  );

  ofe_pipe_bank #(.WIDTH(64), .STAGES(4)) u_d4 (
    .ECLK(ECLK), .GSRN(GSRN), .D(d64), .TD(TD), .SP(SP), .PD(PD),
    .Q(q4), .TQ(tq4), .QVALID(qv4)
  );

  // Clock / reset
  initial begin
    ECLK = 1'b0;
    forever #5 ECLK = ~ECLK;
  end

  // Driver: apply one edge worth of inputs, update the scoreboard, settle.
  task automatic tick(input logic g, input logic p, input logic s, input logic t,
                      input logic [63:0] d);
    GSRN = g;
    PD   = p;
    SP   = s;
    TD   = t;
    d64  = d;
    d8   = d[7:0];
    d1   = d[0];
    @(posedge ECLK);
    if (!g) begin
      exp_q2.delete(); exp_q1.delete(); exp_q4.delete();
      exp2 = {1'b1, 8'h00}; exp1 = {1'b1, 1'b0}; exp4 = {1'b1, 64'h0};
      expv2 = 1'b0; expv1 = 1'b0; expv4 = 1'b0;
    end else if (p) begin
      exp_q2.delete(); exp_q1.delete(); exp_q4.delete();
      exp2 = {1'b1, 8'hFF}; exp1 = {1'b1, 1'b1}; exp4 = {1'b1, {64{1'b1}}};
      expv2 = 1'b0; expv1 = 1'b0; expv4 = 1'b0;
    end else if (s) begin
      exp_q2.push_back({t, d[7:0]});
      exp_q1.push_back({t, d[0]});
      exp_q4.push_back({t, d});
      if (exp_q2.size() == 2) begin exp2 = exp_q2.pop_front(); expv2 = 1'b1; end
      if (exp_q1.size() == 1) begin exp1 = exp_q1.pop_front(); expv1 = 1'b1; end
      if (exp_q4.size() == 4) begin exp4 = exp_q4.pop_front(); expv4 = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000);
    checks++;
    if (q2 !== 8'h00 || tq2 !== 1'b1 || qv2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got q=%h tq=%b qv=%b want q=00 tq=1 qv=0", q2, tq2, qv2);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'(i), {$urandom, $urandom});
      checks++;
      if (q2 !== 8'h00 || tq2 !== 1'b1 || qv2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got q=%h tq=%b qv=%b want q=00 tq=1 qv=0",
                 i, q2, tq2, qv2);
      end
    end
  endtask

  task automatic test_latency();
    tick(1'b1, 1'b0, 1'b1, 1'b1, 64'hA5);
    checks++;
    if (q2 !== 8'h00 || qv2 !== 1'b0) begin
      errors++;
      $display("FAIL latency_e1: got q=%h qv=%b want q=00 qv=0", q2, qv2);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1, 64'h3C);
    checks++;
    if (q2 !== 8'hA5 || tq2 !== 1'b1 || qv2 !== 1'b1) begin
      errors++;
      $display("FAIL latency_e2: got q=%h tq=%b qv=%b want q=a5 tq=1 qv=1", q2, tq2, qv2);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 64'h77);
    checks++;
    if (q2 !== 8'h3C || {tq2, q2} !== exp2 || qv2 !== 1'b1) begin
      errors++;
      $display("FAIL latency_e3: got q=%h tq=%b qv=%b want q=3c tq=1 qv=1", q2, tq2, qv2);
    end
  endtask

  task automatic test_stall();
    logic [8:0]  saved2;
    logic [64:0] saved4;
    logic        savedv2;
    logic        savedv4;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'($urandom), {$urandom, $urandom});
    saved2 = exp2; savedv2 = expv2; saved4 = exp4; savedv4 = expv4;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'(i + 1), ~d64);
      checks++;
      if ({tq2, q2} !== saved2 || qv2 !== savedv2 || {tq4, q4} !== saved4 || qv4 !== savedv4) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h/%b %h/%b want %h/%b %h/%b", i,
                 {tq2, q2}, qv2, {tq4, q4}, qv4, saved2, savedv2, saved4, savedv4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'($urandom), {$urandom, $urandom});
      checks++;
      if ({tq2, q2} !== exp2 || {tq4, q4} !== exp4 || qv2 !== 1'b1 || qv4 !== 1'b1) begin
        errors++;
        $display("FAIL stall_resume[%0d]: got %h %h want %h %h", i,
                 {tq2, q2}, {tq4, q4}, exp2, exp4);
      end
    end
  endtask

  task automatic test_preset();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h55);
    checks++;
    if (q2 !== 8'hFF || tq2 !== 1'b1 || qv2 !== 1'b0 || q4 !== {64{1'b1}} || qv4 !== 1'b0) begin
      errors++;
      $display("FAIL preset_out: got q=%h tq=%b qv=%b q4=%h want q=ff tq=1 qv=0 q4=all ones",
               q2, tq2, qv2, q4);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 64'h5A);
    checks++;
    if (q2 !== 8'hFF || qv2 !== 1'b0) begin
      errors++;
      $display("FAIL preset_adv1: got q=%h qv=%b want q=ff qv=0", q2, qv2);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1, 64'hC3);
    checks++;
    if (q2 !== 8'h5A || tq2 !== 1'b0 || qv2 !== 1'b1 || {tq2, q2} !== exp2) begin
      errors++;
      $display("FAIL preset_adv2: got q=%h tq=%b qv=%b want q=5a tq=0 qv=1", q2, tq2, qv2);
    end
  endtask

  task automatic test_priority();
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'hFF);
    checks++;
    if (q2 !== 8'h00 || tq2 !== 1'b1 || qv2 !== 1'b0 || q4 !== 64'h0) begin
      errors++;
      $display("FAIL prio_reset: got q=%h tq=%b qv=%b q4=%h want q=00 tq=1 qv=0 q4=0",
               q2, tq2, qv2, q4);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 64'h11);
    checks++;
    if (tq2 !== 1'b1 || tq1 !== 1'b0) begin
      errors++;
      $display("FAIL prio_td1: got tq2=%b tq1=%b want tq2=1 tq1=0", tq2, tq1);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 64'h22);
    checks++;
    if (tq2 !== 1'b0 || q2 !== 8'h11 || qv2 !== 1'b1) begin
      errors++;
      $display("FAIL prio_td2: got tq=%b q=%h qv=%b want tq=0 q=11 qv=1", tq2, q2, qv2);
    end
  endtask

  task automatic test_sweep();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1'($urandom), {$urandom, $urandom});
      checks++;
      if (qv1 !== 1'b1 || qv4 !== (k >= 4) || {tq1, q1} !== exp1 || {tq4, q4} !== exp4) begin
        errors++;
        $display("FAIL sweep_prime[%0d]: got qv1=%b qv4=%b q1=%h q4=%h want qv1=1 qv4=%b q1=%h q4=%h",
                 k, qv1, qv4, {tq1, q1}, {tq4, q4}, (k >= 4), exp1, exp4);
      end
    end
    for (int i = 0; i < 100; i++) begin
      tick(1'($urandom_range(0, 31) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom), {$urandom, $urandom});
      checks++;
      if ({tq2, q2} !== exp2 || qv2 !== expv2 || {tq1, q1} !== exp1 || qv1 !== expv1 ||
          {tq4, q4} !== exp4 || qv4 !== expv4) begin
        errors++;
        $display("FAIL sweep_rand[%0d]: got %h/%b %h/%b %h/%b want %h/%b %h/%b %h/%b", i,
                 {tq2, q2}, qv2, {tq1, q1}, qv1, {tq4, q4}, qv4,
                 exp2, expv2, exp1, expv1, exp4, expv4);
      end
      checks++;
      if (int'(u_d2.r_fill_cnt) > 2 || int'(u_d1.r_fill_cnt) > 1 || int'(u_d4.r_fill_cnt) > 4) begin
        errors++;
        $display("FAIL sweep_cnt[%0d]: got %0d %0d %0d want <= 2 1 4", i,
                 u_d2.r_fill_cnt, u_d1.r_fill_cnt, u_d4.r_fill_cnt);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    GSRN = 1'b0; PD = 1'b0; SP = 1'b0; TD = 1'b0;
    d8 = '0; d1 = '0; d64 = '0;
    exp2 = '0; exp1 = '0; exp4 = '0;
    expv2 = 1'b0; expv1 = 1'b0; expv4 = 1'b0;
    @(negedge ECLK);
    test_reset();
    test_latency();
    test_stall();
    test_preset();
    test_priority();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ofe_pipe_bank.md
Name: ofe_pipe_bank

Overview:
- Parametrised output flip-flop bank on the edge clock; successor to the single-bit enable/preset output FF.
- Registers a WIDTH-bit data bus and its tristate control through STAGES pipeline stages, with clock enable and synchronous preset.
- Tracks pipeline priming and flags when the outputs carry real data.
- Sits between fabric logic and the output pad buffers.

Parameters:
- WIDTH, 8, data lanes; 1..64.
- STAGES, 1, pipeline depth ECLK->Q; 1..4.
- INIT_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset.
- PD_VAL, {WIDTH{1'b1}}, value loaded into every data stage on preset.
- TS_INIT, 1'b1, tristate-control reset and preset value; 1 = outputs disabled.

Ports:
- ECLK  input  1  edge clock; all state updates on the rising edge.
- GSRN  input  1  reset; synchronous, active-low.
- D     input  WIDTH  data to output pads.
- TD    input  1  tristate control in; 1 = disable.
- SP    input  1  clock enable for the whole pipe.
- PD    input  1  synchronous preset, active-high.
- Q     output WIDTH  registered data from the last stage.
- TQ    output 1  registered tristate control from the last stage.
- QVALID output 1  high once STAGES enabled advances have occurred since the last reset or preset.

Behaviour:
- Priority at each rising ECLK: GSRN=0 > PD=1 > SP=1 > hold.
- Reset (GSRN=0):
  - all data stages = INIT_VAL; all TS stages = TS_INIT.
  - fill counter = 0; QVALID = 0.
  - Q = INIT_VAL, TQ = TS_INIT, QVALID = 0 from the first edge with GSRN low.
- Preset (GSRN=1, PD=1):
  - all data stages = PD_VAL; all TS stages = TS_INIT; fill counter = 0; QVALID = 0.
  - SP is ignored.
- Advance (GSRN=1, PD=0, SP=1):
  - stage[0] <= D, TS[0] <= TD; stage[i] <= stage[i-1] for i = 1..STAGES-1.
  - fill counter increments, saturating at STAGES.
- Hold (SP=0): all stages, the fill counter and QVALID are unchanged. A stall mid-priming freezes the count.
- Latency: D sampled on advance edge k appears on Q after the STAGES-th advance edge counting k. With continuous SP, latency is STAGES cycles.
- QVALID = 1 iff fill counter == STAGES. The flag is registered and changes on the same edge as the final priming advance.
- Fill counter width = clog2(STAGES+1). It saturates and never wraps.
- Q, TQ and QVALID are driven directly from flops; there is no combinational path from D, SP or PD to any output.
- Reset or preset mid-priming, or after QVALID=1: counter returns to 0 and priming restarts on the next advance.
- GSRN and PD asserted together: reset wins, so data stages = INIT_VAL.
- No X propagation from the control path: SP, PD and TD are sampled only when GSRN=1.

Decomposition:
- Shared package ofe_pkg holds:
  - OFE_MAX_STAGES = 4.
  - the clog2 function.
  - the typedef for the fill counter.
- One natural sub-module, ofe_stage: a single WIDTH+1-bit register slice with reset/preset/enable.
  - ofe_pipe_bank instantiates STAGES copies of it in a generate loop.
  - the fill counter and QVALID logic live in the top.

Test Plan:
- Reset: WIDTH=8, STAGES=2; hold GSRN=0 for 2 edges -> Q=8'h00, TQ=1, QVALID=0; release and keep SP=0 for 5 edges -> no change.
- Latency and priming: SP=1, D=8'hA5 then 8'h3C on consecutive edges -> QVALID=1 after edge 2, Q=8'hA5 after edge 2, Q=8'h3C after edge 3.
- Stall: prime, then SP=0 for 3 cycles while D toggles -> Q, TQ and QVALID frozen; SP=1 resumes the original order with no lost or duplicated word.
- Preset: after priming, PD=1 for one edge with SP=1 -> Q=8'hFF, TQ=1, QVALID=0; it takes 2 further advances to reach QVALID=1.
- Priority: GSRN=0 and PD=1 on the same edge -> Q=INIT_VAL (8'h00), not 8'hFF. TD=0 advanced -> TQ=0 after STAGES advances.
- Sweep: STAGES=1,4 and WIDTH=1,64 -> latency equals STAGES; QVALID rises exactly on the STAGES-th advance; counter never exceeds STAGES over 100 random SP cycles.
